// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int BUSY_TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin pick among byte producers, scanning from i_rr_ptr+1 with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_any_valid
);

  localparam int IDW = $clog2(NUM_REQ);

  logic           w_found;
  logic [IDW-1:0] w_idx;

  // Position k steps after p, wrapping at NUM_REQ (works for non power-of-two counts).
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // First set valid after the pointer wins; the pointer itself is checked last.
  always_comb begin
    o_grant     = '0;
    o_grant_id  = '0;
    o_any_valid = |i_valid;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = wrap_add(i_rr_ptr, k);
      if (!w_found && i_valid[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_id     = w_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte producers (round-robin, packet lock).
// Latency: req_valid sampled in IDLE at edge k -> tx_start/req_ready high in cycle k+1.
// Backpressure: producers hold their byte until req_ready; nothing starts while tx_busy=1.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           grant_lock,
  output logic                           timeout_err
);

  localparam int IDW  = $clog2(NUM_REQ);
  // Counter holds cycles elapsed since tx_start, so it must reach BUSY_TIMEOUT-1 (needs >= 2).
  localparam int CNTW = $clog2(BUSY_TIMEOUT + 1);

  state_t                  r_state;
  logic [IDW-1:0]          r_rr_ptr;
  logic [CNTW-1:0]         r_cnt;
  logic [UART_DATA_W-1:0]  r_tx_data;
  logic [IDW-1:0]          r_grant_id;
  logic                    r_grant_lock;
  logic                    r_tx_start;
  logic [NUM_REQ-1:0]      r_req_ready;
  logic                    r_timeout_err;

  logic [NUM_REQ-1:0]      w_win_onehot;
  logic [IDW-1:0]          w_win_id;
  logic                    w_any_valid;
  logic [UART_DATA_W-1:0]  w_win_data;
  logic                    w_win_last;
  logic                    w_own_valid;
  logic [UART_DATA_W-1:0]  w_own_data;
  logic                    w_own_last;
  logic [NUM_REQ-1:0]      w_own_onehot;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_valid     (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_win_onehot),
    .o_grant_id  (w_win_id),
    .o_any_valid (w_any_valid)
  );

  // Lane of the arbitration winner, and lane of the current owner for locked packets.
  assign w_win_data   = req_data[int'(w_win_id)*UART_DATA_W +: UART_DATA_W];
  assign w_win_last   = req_last[w_win_id];
  assign w_own_valid  = req_valid[r_grant_id];
  assign w_own_data   = req_data[int'(r_grant_id)*UART_DATA_W +: UART_DATA_W];
  assign w_own_last   = req_last[r_grant_id];
  assign w_own_onehot = NUM_REQ'(1) << r_grant_id;

  // FSM: arbitrate, latch one byte, pulse tx_start, then track tx_busy with a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= IDW'(NUM_REQ - 1);
      r_cnt         <= '0;
      r_tx_data     <= '0;
      r_grant_id    <= '0;
      r_grant_lock  <= 1'b0;
      r_tx_start    <= 1'b0;
      r_req_ready   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_start    <= 1'b0;
      r_req_ready   <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          // tx_busy gate also covers a reset that landed in the middle of a frame.
          if (!tx_busy && w_any_valid) begin
            r_tx_data    <= w_win_data;
            r_grant_id   <= w_win_id;
            r_grant_lock <= ~w_win_last;
            r_tx_start   <= 1'b1;
            r_req_ready  <= w_win_onehot;
            r_state      <= START;
          end
        end
        START: begin
          r_cnt   <= CNTW'(1);
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_cnt == CNTW'(BUSY_TIMEOUT - 1)) begin
            // Byte is dropped as sent; any open packet is abandoned.
            r_timeout_err <= 1'b1;
            r_grant_lock  <= 1'b0;
            r_rr_ptr      <= r_grant_id;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (!r_grant_lock) begin
              r_rr_ptr <= r_grant_id;
              r_state  <= IDLE;
            end else if (w_own_valid) begin
              r_tx_data    <= w_own_data;
              r_grant_lock <= ~w_own_last;
              r_tx_start   <= 1'b1;
              r_req_ready  <= w_own_onehot;
              r_state      <= START;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          // Locked owner keeps the transmitter; everyone else waits.
          if (w_own_valid) begin
            r_tx_data    <= w_own_data;
            r_grant_lock <= ~w_own_last;
            r_tx_start   <= 1'b1;
            r_req_ready  <= w_own_onehot;
            r_state      <= START;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;
  assign grant_lock  = r_grant_lock;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized scoreboard bench for uart_tx_scheduler with a behavioural UART busy model.
// Expected byte order is computed per packet by rotation over pending producer queues.
// Monitor pops the scoreboard at every tx_start and checks timeout pulse timing.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int T  = 16;
  localparam int IW = $clog2(N);

  typedef struct {
    int         id;
    logic [7:0] dat;
    logic       last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic [IW-1:0]   grant_id;
  logic            grant_lock;
  logic            timeout_err;

  // Producer byte stores: {last, data}; main appends at ptail, driver consumes at phead.
  logic [8:0] pmem [N][512];
  int         ptail [N];
  int         phead [N];
  int         pstall [N];
  int         mstart [N];
  int         mptr;

  exp_t expq[$];
  int   tq[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  int no_busy     = 0;
  int force_stall = 0;
  int stall_max   = 0;
  int frame_min   = 8;
  int frame_max   = 20;
  int u_dly       = 0;
  int u_len       = 0;

  logic [7:0] cap_dat;
  logic       cap_vld   = 1'b0;
  logic       prev_busy = 1'b0;

  uart_tx_scheduler #(
    .NUM_REQ      (N),
    .BUSY_TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .grant_lock  (grant_lock),
    .timeout_err (timeout_err)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  task automatic add_byte(input int id, input logic [7:0] dat, input logic last);
    pmem[id][ptail[id]] = {last, dat};
    ptail[id]++;
  endtask

  // Reference: whole packets are served in rotation after the last served producer.
  task automatic model_commit();
    int   cur [N];
    int   j;
    bit   any;
    exp_t e;
    for (int i = 0; i < N; i++) cur[i] = mstart[i];
    forever begin
      any = 1'b0;
      j   = 0;
      for (int k = 1; k <= N; k++) begin
        j = (mptr + k) % N;
        if (cur[j] < ptail[j]) begin
          any = 1'b1;
          break;
        end
      end
      if (!any) break;
      do begin
        e.id   = j;
        e.dat  = pmem[j][cur[j]][7:0];
        e.last = pmem[j][cur[j]][8];
        expq.push_back(e);
        cur[j]++;
      end while (!e.last);
      mptr = j;
    end
    for (int i = 0; i < N; i++) mstart[i] = ptail[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expq.delete();
    mptr = N - 1;
    for (int i = 0; i < N; i++) mstart[i] = ptail[i];
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (expq.size() == 0 && !tx_busy && u_dly == 0) quiet++;
      else quiet = 0;
      if (quiet >= T + 4) return;
    end
    fail_now("drain_timeout");
  endtask

  // Producers and UART busy model: sample at negedge, update 1 time unit after posedge.
  initial begin : driver
    logic [N-1:0] s_rdy;
    logic         s_start;
    logic         lb;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    for (int i = 0; i < N; i++) begin
      phead[i]  = 0;
      pstall[i] = 0;
    end
    forever begin
      @(negedge clk);
      s_rdy   = req_ready;
      s_start = tx_start;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          phead[i]  = ptail[i];
          pstall[i] = 0;
        end else if (s_rdy[i]) begin
          lb = pmem[i][phead[i]][8];
          phead[i]++;
          if (!lb) pstall[i] = (force_stall > 0) ? force_stall : int'($urandom_range(stall_max, 0));
        end else if (pstall[i] > 0) begin
          pstall[i]--;
        end
        if (!rst && phead[i] < ptail[i] && pstall[i] == 0) begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = pmem[i][phead[i]][7:0];
          req_last[i]       = pmem[i][phead[i]][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      if (s_start && no_busy == 0) u_dly = int'($urandom_range(2, 1));
      if (u_dly > 0) begin
        u_dly--;
        if (u_dly == 0) begin
          tx_busy = 1'b1;
          u_len   = int'($urandom_range(frame_max, frame_min));
        end
      end else if (tx_busy) begin
        u_len--;
        if (u_len <= 0) tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every tx_start must match the next expected byte.
  initial begin : monitor
    exp_t e;
    int   tdue;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        cap_vld   = 1'b0;
        prev_busy = tx_busy;
        tq.delete();
        continue;
      end
      if (tx_start) begin
        check("start_while_busy", tx_busy, 0);
        if (expq.size() == 0) begin
          fail_now("unexpected_start");
        end else begin
          e = expq.pop_front();
          check("tx_data", tx_data, e.dat);
          check("grant_id", grant_id, e.id);
          check("req_ready", req_ready, 1 << e.id);
          check("grant_lock", grant_lock, !e.last);
        end
        cap_dat = tx_data;
        cap_vld = 1'b1;
        if (no_busy != 0) tq.push_back(cyc + T);
      end else if (req_ready != '0) begin
        check("ready_outside_start", req_ready, 0);
      end
      if (timeout_err) begin
        if (tq.size() == 0) fail_now("unexpected_timeout");
        else begin
          tdue = tq.pop_front();
          check("timeout_cycle", cyc, tdue);
        end
      end
      if (prev_busy && !tx_busy && cap_vld) begin
        check("loopback", tx_data, cap_dat);
        cap_vld = 1'b0;
      end
      prev_busy = tx_busy;
    end
  end

  initial begin : main
    int got_busy;
    for (int i = 0; i < N; i++) begin
      ptail[i]  = 0;
      mstart[i] = 0;
    end
    mptr = N - 1;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_grant_lock", grant_lock, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;

    // Single byte from requester 0.
    add_byte(0, 8'hAA, 1'b1);
    model_commit();
    wait_idle(2000);
    check("single_lock", grant_lock, 0);
    check("single_gid", grant_id, 0);
    check("single_held", tx_data, 8'hAA);

    // Round-robin over requesters 0, 1, 3.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      add_byte(0, 8'h10 + 8'(k), 1'b1);
      add_byte(1, 8'h20 + 8'(k), 1'b1);
      add_byte(3, 8'h30 + 8'(k), 1'b1);
    end
    model_commit();
    wait_idle(3000);

    // Packet lock with a long stall between req 2 bytes; req 1 must wait.
    do_reset();
    force_stall = 40;
    add_byte(2, 8'h11, 1'b0);
    add_byte(2, 8'h22, 1'b1);
    model_commit();
    repeat (4) @(negedge clk);
    add_byte(1, 8'h55, 1'b1);
    model_commit();
    repeat (26) @(negedge clk);
    check("hold_lock", grant_lock, 1);
    check("hold_gid", grant_id, 2);
    wait_idle(3000);
    force_stall = 0;

    // Transmitter never goes busy: each byte times out, next requester served.
    do_reset();
    no_busy = 1;
    add_byte(0, 8'hC3, 1'b1);
    add_byte(1, 8'h3C, 1'b1);
    model_commit();
    wait_idle(2000);
    check("timeout_lock", grant_lock, 0);
    no_busy = 0;

    // Reset in the middle of a locked frame.
    do_reset();
    frame_min = 30;
    frame_max = 30;
    add_byte(1, 8'hA0, 1'b0);
    add_byte(1, 8'hA1, 1'b1);
    model_commit();
    got_busy = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_busy) begin
        got_busy = 1;
        break;
      end
    end
    if (got_busy == 0) fail_now("midframe_busy");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_tx_start", tx_start, 0);
    check("mid_req_ready", req_ready, 0);
    check("mid_tx_data", tx_data, 0);
    check("mid_grant_id", grant_id, 0);
    check("mid_grant_lock", grant_lock, 0);
    check("mid_timeout_err", timeout_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expq.delete();
    mptr = N - 1;
    for (int i = 0; i < N; i++) mstart[i] = ptail[i];
    add_byte(2, 8'h77, 1'b1);
    add_byte(0, 8'h88, 1'b1);
    model_commit();
    wait_idle(3000);

    // Randomized packets, frame lengths and mid-packet stalls.
    frame_min = 4;
    frame_max = 16;
    stall_max = 6;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        int npk;
        npk = int'($urandom_range(2, 0));
        for (int p = 0; p < npk; p++) begin
          int len;
          len = int'($urandom_range(4, 1));
          for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), (b == len - 1));
        end
      end
      model_commit();
      wait_idle(4000);
    end

    check("leftover_expected", expq.size(), 0);
    check("leftover_timeouts", tq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single uart_top transmitter among NUM_REQ byte producers.
- Uses round-robin arbitration with optional packet lock: a granted requester keeps the transmitter until it presents a byte with req_last=1.
- Sequences uart_top's tx_start/tx_data against tx_busy, one byte at a time.
- Sits between the command/response logic and uart_top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 16, clk cycles to wait for tx_busy to rise after tx_start before flagging an error.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte on its data lane.
- req_data  in  8*NUM_REQ  packed bytes; requester i on bits [8i+7:8i].
- req_last  in  NUM_REQ  current byte of requester i ends its packet.
- req_ready  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- tx_start  out  1  one-cycle start pulse to uart_top.
- tx_data  out  8  byte to uart_top; held stable from tx_start until the next load.
- tx_busy  in  1  uart_top transmitter busy.
- grant_id  out  clog2(NUM_REQ)  current or last granted requester.
- grant_lock  out  1  packet lock held.
- timeout_err  out  1  one-cycle pulse: tx_busy never rose.

Behaviour:
- Reset (async, while rst=1): req_ready=0, tx_start=0, tx_data=0, grant_id=0, grant_lock=0, timeout_err=0, state=IDLE, rr_ptr=NUM_REQ-1 so requester 0 wins first.
- Requester rule: hold req_valid, req_data and req_last stable until req_ready[i] is seen. The byte counts as consumed on the edge where req_ready[i]=1.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE:
  - Arbitrates only when tx_busy=0 and any req_valid=1.
  - Winner is the first set req_valid scanning from rr_ptr+1 with wrap-around.
  - On the edge: latch tx_data=req_data[winner], grant_id=winner, grant_lock=~req_last[winner]; go to START.
- START (exactly 1 cycle): tx_start=1 and req_ready[grant_id]=1. Clear wait counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 -> WAIT_DONE.
  - Counter reaching BUSY_TIMEOUT -> timeout_err pulse, grant_lock=0, rr_ptr=grant_id, go to IDLE. The byte is counted as sent; no retry.
- WAIT_DONE: on tx_busy=0:
  - grant_lock=0: rr_ptr=grant_id, go to IDLE.
  - grant_lock=1 and req_valid[grant_id]=1: latch the next byte, update grant_lock=~req_last, go to START directly (back-to-back).
  - grant_lock=1 and req_valid[grant_id]=0: go to HOLD.
- HOLD:
  - Other requesters are ignored.
  - When req_valid[grant_id]=1: latch the byte and go to START, as in WAIT_DONE.
- Latency: req_valid sampled in IDLE at edge k -> tx_start high in cycle k+1.
- Simultaneous events:
  - Several valids in IDLE: rotation order decides.
  - req_valid dropping during START is a protocol violation; the byte is already latched.
- Reset mid-byte: uart_top may still be busy. After rst the block stays in IDLE until tx_busy=0, so no tx_start is issued during a frame.
- tx_start and req_ready are never asserted outside START. At most one req_ready bit is high at a time.

Decomposition:
- uart_pkg holds:
  - state enum (IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD);
  - UART_DATA_W=8;
  - default BUSY_TIMEOUT.
- Sub-module uart_rr_arbiter:
  - combinational round-robin pick;
  - inputs: NUM_REQ valids and rr_ptr;
  - outputs: one-hot grant, grant index, any_valid.
- Top holds the FSM, the latches and the timeout counter.

Test Plan:
- Single byte: after reset, req_valid[0]=1, data 8'hAA, last=1 -> one tx_start; tx_data=8'hAA; req_ready[0] pulses once; grant_lock=0. Loopback rx_data=8'hAA.
- Round-robin: valids on req 0, 1 and 3 held continuously, all last=1 -> transmit order 0, 1, 3, 0, ...; every gap between tx_start pulses is at least one full frame.
- Packet lock:
  - Stimulus: req 2 sends 8'h11, 8'h22 (last); req 1 valid throughout.
  - Required: bytes 11, 22 go out contiguously, then req 1.
  - Stalling req 2 between its bytes holds HOLD, and req 1 waits.
- Timeout: tx_busy tied to 0 -> timeout_err pulses 16 cycles after tx_start; FSM returns to IDLE and the next requester is served.
- Reset mid-frame: assert rst during WAIT_DONE while tx_busy=1 -> all outputs 0 immediately; no tx_start until tx_busy falls; the first grant goes to req 0.
